// File: rtl/onehot_scan_decoder.sv
// rtl/onehot_scan_decoder.sv - registered one-hot line decoder with request port and optional auto-scan
//
// Purpose: registers a selected line index and drives it as a one-hot select
// that holds steady between requests. With ONEHOT_SCAN_DECODER_SCAN_EN defined,
// an auto-scan walks a single asserted line from bit 0 to the top bit, holding
// each line for (dwell + 1) cycles.
//
// Ports:
//   clk        - rising-edge clock
//   rst_n      - asynchronous active-low reset
//   enabler    - output enable, gates out combinationally, state is unaffected
//   clear      - synchronous return to IDLE, cur_sel retained
//   req_valid  - decode request
//   req_sel    - requested line index
//   req_ready  - request can be accepted this cycle
//   scan_start - start an auto-scan (ONEHOT_SCAN_DECODER_SCAN_EN only)
//   dwell      - per-line hold time minus one (ONEHOT_SCAN_DECODER_SCAN_EN only)
//   scan_done  - one-cycle pulse in the final scan cycle (ONEHOT_SCAN_DECODER_SCAN_EN only)
//   out        - one-hot line select
//   out_valid  - a line is selected (DRIVE or SCAN)
//   cur_sel    - index of the selected line

module onehot_scan_decoder #(
  parameter int SEL_W   = 4,
  parameter int DWELL_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enabler,
  input  logic                    clear,
  input  logic                    req_valid,
  input  logic [SEL_W-1:0]        req_sel,
  output logic                    req_ready,
`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
  input  logic                    scan_start,
  input  logic [DWELL_W-1:0]      dwell,
  output logic                    scan_done,
`endif
  output logic [(1<<SEL_W)-1:0]   out,
  output logic                    out_valid,
  output logic [SEL_W-1:0]        cur_sel
);

  localparam logic [SEL_W-1:0] SEL_MAX = '1;

  // Elaboration stops on parameters outside the supported range.
  if (SEL_W < 1 || SEL_W > 8 || DWELL_W < 1) begin : g_param_check
    $error("onehot_scan_decoder: SEL_W must be 1..8 and DWELL_W at least 1");
  end

`ifdef ONEHOT_SCAN_DECODER_SCAN_EN

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_SCAN  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic               req_ready_q, req_ready_d;
  logic               scan_done_q, scan_done_d;

  // Priority: clear > scan_start > req_valid. In SCAN the request port is
  // closed (req_ready low) and scan_start is ignored.
  always_comb begin
    state_d   = state_q;
    cur_sel_d = cur_sel_q;
    cnt_d     = cnt_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DRIVE: begin
          if (scan_start) begin
            state_d   = S_SCAN;
            cur_sel_d = '0;
            cnt_d     = dwell;
          end else if (req_valid) begin
            state_d   = S_DRIVE;
            cur_sel_d = req_sel;
          end
        end
        S_SCAN: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (cur_sel_q != SEL_MAX) begin
            // Reload from the live dwell input so the hold time can be
            // retuned while a scan is in progress.
            cur_sel_d = cur_sel_q + 1'b1;
            cnt_d     = dwell;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs are registered: compute their values for the next state.
    out_valid_d = (state_d != S_IDLE);
    req_ready_d = (state_d != S_SCAN);
    // The final scan cycle is the one where the next edge leaves SCAN.
    scan_done_d = (state_d == S_SCAN) && (cnt_d == '0) && (cur_sel_d == SEL_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cur_sel_q   <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
      scan_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_sel_q   <= cur_sel_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      req_ready_q <= req_ready_d;
      scan_done_q <= scan_done_d;
    end
  end

  assign req_ready = req_ready_q;
  assign scan_done = scan_done_q;

`else

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRIVE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
  logic             out_valid_q, out_valid_d;

  always_comb begin
    state_d   = state_q;
    cur_sel_d = cur_sel_q;
    if (clear) begin
      state_d = S_IDLE;
    end else if (req_valid) begin
      state_d   = S_DRIVE;
      cur_sel_d = req_sel;
    end
    out_valid_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cur_sel_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_sel_q   <= cur_sel_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Without scanning there is no state that refuses a request.
  assign req_ready = 1'b1;

`endif

  assign out_valid = out_valid_q;
  assign cur_sel   = cur_sel_q;

  // enabler gates the select with no register in the path.
  always_comb begin
    out = '0;
    if (out_valid_q && enabler) begin
      out[cur_sel_q] = 1'b1;
    end
  end

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// tb/tb_onehot_scan_decoder.sv - directed scoreboard bench for onehot_scan_decoder

module tb_onehot_scan_decoder;

  logic        clk;
  logic        rst_n;
  logic        enabler;
  logic        clear;
  logic        req_valid;
  logic [3:0]  req_sel;
  logic        req_ready;
  logic [15:0] out;
  logic        out_valid;
  logic [3:0]  cur_sel;
`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
  logic        scan_start;
  logic [7:0]  dwell;
  logic        scan_done;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [15:0] o;
    logic        v;
    logic [3:0]  s;
  } exp_t;

  exp_t sb[$];

  onehot_scan_decoder #(.SEL_W(4), .DWELL_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enabler    (enabler),
    .clear      (clear),
    .req_valid  (req_valid),
    .req_sel    (req_sel),
    .req_ready  (req_ready),
`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
    .scan_start (scan_start),
    .dwell      (dwell),
    .scan_done  (scan_done),
`endif
    .out        (out),
    .out_valid  (out_valid),
    .cur_sel    (cur_sel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] o, input logic v, input logic [3:0] s);
    exp_t e;
    e.o = o;
    e.v = v;
    e.s = s;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_out"}, {16'd0, out}, {16'd0, e.o});
      chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, e.v});
      chk({tag, "_sel"}, {28'd0, cur_sel}, {28'd0, e.s});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] one;
    one       = 16'h0001;
    rst_n     = 1'b0;
    enabler   = 1'b1;
    clear     = 1'b0;
    req_valid = 1'b1;
    req_sel   = 4'd5;
`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
    scan_start = 1'b0;
    dwell      = 8'd2;
`endif

    // Reset state with a request already pending.
    #12;
    push(16'h0000, 1'b0, 4'd0);
    pop_chk("reset");
    chk("reset_ready", {31'd0, req_ready}, 32'd1);
`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
    chk("reset_done", {31'd0, scan_done}, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // First request: out one cycle after acceptance.
    push(16'h0020, 1'b1, 4'd5);
    tick();
    pop_chk("first_req");

    // Back-to-back requests.
    req_sel = 4'd3;  push(16'h0008, 1'b1, 4'd3);
    tick(); pop_chk("b2b_3");  chk("b2b_3_ready", {31'd0, req_ready}, 32'd1);
    req_sel = 4'd12; push(16'h1000, 1'b1, 4'd12);
    tick(); pop_chk("b2b_12"); chk("b2b_12_ready", {31'd0, req_ready}, 32'd1);
    req_sel = 4'd0;  push(16'h0001, 1'b1, 4'd0);
    tick(); pop_chk("b2b_0");  chk("b2b_0_ready", {31'd0, req_ready}, 32'd1);

    // Enable gating in DRIVE with cur_sel=7.
    req_sel = 4'd7;  push(16'h0080, 1'b1, 4'd7);
    tick(); pop_chk("drive_7");
    req_valid = 1'b0;
    enabler   = 1'b0;
    #1;
    push(16'h0000, 1'b1, 4'd7); pop_chk("gate_c1");
    tick();
    push(16'h0000, 1'b1, 4'd7); pop_chk("gate_c2");
    enabler = 1'b1;
    #1;
    push(16'h0080, 1'b1, 4'd7); pop_chk("gate_restore");
    push(16'h0080, 1'b1, 4'd7);
    tick(); pop_chk("drive_hold");

    // clear returns to IDLE and keeps cur_sel; clear beats a request.
    clear = 1'b1;
    req_valid = 1'b1;
    req_sel = 4'd9;
    push(16'h0000, 1'b0, 4'd7);
    tick(); pop_chk("clear_vs_req");
    clear = 1'b0;

    // Top line.
    req_sel = 4'd15; push(16'h8000, 1'b1, 4'd15);
    tick(); pop_chk("req_15");
    req_valid = 1'b0;

`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
    // Full scan, request in the same cycle as scan_start is not accepted.
    scan_start = 1'b1;
    req_valid  = 1'b1;
    req_sel    = 4'd9;
    dwell      = 8'd2;
    for (int k = 1; k <= 48; k++) begin
      push(one << ((k - 1) / 3), 1'b1, 4'((k - 1) / 3));
      tick();
      scan_start = 1'b0;
      pop_chk($sformatf("scan_c%0d", k));
      chk($sformatf("scan_ready_c%0d", k), {31'd0, req_ready}, 32'd0);
      chk($sformatf("scan_done_c%0d", k), {31'd0, scan_done}, (k == 48) ? 32'd1 : 32'd0);
    end
    req_valid = 1'b0;
    push(16'h0000, 1'b0, 4'd15);
    tick(); pop_chk("scan_end");
    chk("scan_end_done", {31'd0, scan_done}, 32'd0);
    chk("scan_end_ready", {31'd0, req_ready}, 32'd1);

    // clear at scan cycle 10: IDLE next cycle, no scan_done.
    scan_start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      scan_start = 1'b0;
    end
    chk("pre_clear_sel", {28'd0, cur_sel}, 32'd3);
    clear = 1'b1;
    push(16'h0000, 1'b0, 4'd3);
    tick(); pop_chk("scan_clear");
    chk("scan_clear_done", {31'd0, scan_done}, 32'd0);
    clear = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("post_clear_done_%0d", k), {31'd0, scan_done}, 32'd0);
    end

    // Asynchronous reset mid-scan.
    scan_start = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      scan_start = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    push(16'h0000, 1'b0, 4'd0);
    pop_chk("async_rst_scan");
    chk("async_rst_done", {31'd0, scan_done}, 32'd0);
    chk("async_rst_ready", {31'd0, req_ready}, 32'd1);
`else
    // Asynchronous reset in DRIVE between clock edges.
    req_valid = 1'b1;
    req_sel   = 4'd10;
    push(16'h0400, 1'b1, 4'd10);
    tick(); pop_chk("pre_rst_req");
    req_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    push(16'h0000, 1'b0, 4'd0);
    pop_chk("async_rst_drive");
`endif

    chk("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
